store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Posted-write FIFO between the datapath's store path and the byte-addressed 64-bit data memory.
- Accepts doubleword stores in one cycle and drains them to memory in order whenever the memory port is free.
- Forwards buffered data to loads on an exact address match.
- Flags partial-overlap loads so the control unit can stall until the conflicting entries have drained.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, 2..16.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- st_valid  input  1  datapath presents a doubleword store this cycle.
- st_addr  input  64  store byte address.
- st_data  input  64  store data.
- st_ready  output  1  entry free; a store is accepted when st_valid && st_ready.
- ld_valid  input  1  datapath performs a doubleword load this cycle.
- ld_addr  input  64  load byte address.
- ld_hit  output  1  some valid entry's address equals ld_addr.
- ld_data  output  64  data of the youngest matching entry; 0 when ld_hit=0.
- ld_conflict  output  1  some valid entry overlaps ld_addr by 1..7 bytes; the datapath must stall.
- drain_en  input  1  memory port free this cycle (no load using it).
- mem_write  output  1  write strobe to data memory.
- mem_addr  output  64  write address to data memory.
- write_data  output  64  write data to data memory.
- count  output  PTR_W+1  number of valid entries.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.

Behaviour:
- Storage
  - Circular array of {addr, data} entries with head (oldest), tail and count registers.
  - Entry contents are not reset; only the pointers and count are reset.
- Reset
  - On a rising edge with reset=1: head=0, tail=0, count=0.
  - Outputs then read: st_ready=1, empty=1, full=0, mem_write=0, ld_hit=0, ld_conflict=0, ld_data=0.
  - Reset has priority over any simultaneous store or drain; all pending entries are discarded.
- Enqueue
  - st_ready = !full (registered-state derived, no same-cycle bypass).
  - st_valid && st_ready writes st_addr/st_data at tail; tail = tail+1 mod DEPTH.
  - When full, a store is not accepted even if a drain occurs in the same cycle; the datapath holds the store.
- Drain
  - mem_write = !empty && drain_en; mem_addr/write_data = head entry (combinational from registered state).
  - When mem_write=1, head = head+1 mod DEPTH at the rising edge.
  - The memory commits on the falling edge of the same cycle; drain latency is 0 cycles after drain_en, one entry per cycle, strictly FIFO order.
  - mem_addr and write_data are don't-care when mem_write=0.
- Count
  - count += accept, and count -= drain.
  - Simultaneous accept and drain leaves count unchanged.
  - Pointer wrap is modulo DEPTH.
- Forwarding (combinational; evaluated only when ld_valid=1, otherwise ld_hit=0, ld_conflict=0, ld_data=0)
  - Only valid entries, oldest to youngest starting at head, are searched.
  - The entry being drained this cycle still counts as valid.
  - ld_hit: any entry with addr == ld_addr. ld_data is taken from the youngest such entry.
  - ld_conflict: any entry with addr != ld_addr and |addr - ld_addr| < 8 (64-bit unsigned difference, no wrap at 2^64).
  - If both a hit and a conflict exist, ld_conflict=1 and ld_hit=0. The stall wins and the load retries after the drains.
  - A store accepted in the current cycle is not visible to forwarding until the next cycle.
- Width rules
  - Addresses are compared at full 64 bits; no alignment is required.
  - The memory itself handles the byte split.

Test Plan:
- Reset then 4 stores (addr 0,8,16,24; data 0x11..0x44) with drain_en=0 -> count=4, full=1, st_ready=0; a 5th store (addr 32) is not accepted and count stays 4.
- drain_en=1 for 4 cycles -> mem_write=1 each cycle with mem_addr 0,8,16,24 in order; memory elements read 0x11,0x22,0x33,0x44; then empty=1, mem_write=0.
- Stores addr 8 data 0xAA, then addr 8 data 0xBB, with drain_en=0; load addr 8 -> ld_hit=1, ld_data=0xBB; load addr 40 -> ld_hit=0, ld_data=0.
- Store addr 16 buffered; load addr 20 -> ld_conflict=1, ld_hit=0; drain_en=1 for one cycle -> ld_conflict=0 next cycle.
- count=2 with st_valid=1 and drain_en=1 in the same cycle -> count stays 2 and the head advances; wrap: 6 store/drain pairs with DEPTH=4 -> data order preserved.
- 3 entries buffered, reset=1 for one cycle alongside st_valid and drain_en -> count=0, empty=1, and no further mem_write for the discarded entries.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of doubleword stores drained in order to
// data memory, with exact-match load forwarding and partial-overlap detection.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [63:0]       st_addr,
  input  logic [63:0]       st_data,
  output logic              st_ready,
  input  logic              ld_valid,
  input  logic [63:0]       ld_addr,
  output logic              ld_hit,
  output logic [63:0]       ld_data,
  output logic              ld_conflict,
  input  logic              drain_en,
  output logic              mem_write,
  output logic [63:0]       mem_addr,
  output logic [63:0]       write_data,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full
);

  logic [63:0]      addr_q [DEPTH];
  logic [63:0]      data_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             accept;
  logic             drain;

  assign full       = count_q == (PTR_W+1)'(DEPTH);
  assign empty      = count_q == '0;
  assign count      = count_q;
  assign st_ready   = !full;
  assign accept     = st_valid && st_ready;
  assign mem_write  = !empty && drain_en;
  assign drain      = mem_write;
  assign mem_addr   = addr_q[head_q];
  assign write_data = data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (accept) tail_d = tail_q + 1'b1;
    if (drain)  head_d = head_q + 1'b1;
    unique case ({accept, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads carry no reset; only pointers define validity.
  always_ff @(posedge clk) begin
    if (accept && !reset) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

  logic             hit_any;
  logic             cf_any;
  logic [63:0]      fwd_data;
  logic [PTR_W-1:0] idx;
  logic [63:0]      diff;

  // Oldest-to-youngest scan so the last match wins.
  always_comb begin
    hit_any  = 1'b0;
    cf_any   = 1'b0;
    fwd_data = '0;
    idx      = '0;
    diff     = '0;
    if (ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head_q + PTR_W'(i);
        if ((PTR_W+1)'(i) < count_q) begin
          diff = (addr_q[idx] >= ld_addr) ? addr_q[idx] - ld_addr
                                          : ld_addr - addr_q[idx];
          if (diff == 64'd0) begin
            hit_any  = 1'b1;
            fwd_data = data_q[idx];
          end else if (diff < 64'd8) begin
            cf_any = 1'b1;
          end
        end
      end
    end
  end

  assign ld_conflict = cf_any;
  assign ld_hit      = hit_any && !cf_any;
  assign ld_data     = ld_hit ? fwd_data : 64'd0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed table-driven bench for store_buffer with a falling-edge
// memory model and hand-written reset corner sequence.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [63:0] st_addr;
  logic [63:0] st_data;
  logic        st_ready;
  logic        ld_valid;
  logic [63:0] ld_addr;
  logic        ld_hit;
  logic [63:0] ld_data;
  logic        ld_conflict;
  logic        drain_en;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] write_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int nerr = 0;
  int nchk = 0;

  logic [63:0] mem [longint unsigned];

  always #5 clk = ~clk;

  always @(negedge clk)
    if (mem_write === 1'b1) mem[mem_addr] = write_data;

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .ld_data(ld_data), .ld_conflict(ld_conflict),
    .drain_en(drain_en),
    .mem_write(mem_write), .mem_addr(mem_addr), .write_data(write_data),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    logic        sv;
    logic [63:0] sa;
    logic [63:0] sd;
    logic        lv;
    logic [63:0] la;
    logic        de;
    logic [2:0]  cnt;
    logic        mw;
    logic [63:0] ma;
    logic [63:0] wd;
    logic        hit;
    logic [63:0] ldd;
    logic        cf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    logic sv, logic [63:0] sa, logic [63:0] sd,
    logic lv, logic [63:0] la, logic de,
    logic [2:0] cnt, logic mw, logic [63:0] ma, logic [63:0] wd,
    logic hit, logic [63:0] ldd, logic cf);
    vec_t v;
    v.sv = sv; v.sa = sa; v.sd = sd;
    v.lv = lv; v.la = la; v.de = de;
    v.cnt = cnt; v.mw = mw; v.ma = ma; v.wd = wd;
    v.hit = hit; v.ldd = ldd; v.cf = cf;
    return v;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic sv, logic [63:0] sa, logic [63:0] sd,
                       logic lv, logic [63:0] la, logic de);
    st_valid = sv; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_addr = la; drain_en = de;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_mem(longint unsigned a, logic [63:0] exp);
    if (mem.exists(a)) chk($sformatf("mem[%0h]", a), mem[a], exp);
    else               chk($sformatf("mem[%0h].exists", a), 64'd0, 64'd1);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    //         sv sa      sd    lv la     de  cnt mw ma     wd    hit ldd  cf
    vecs.push_back(mk(0, 0,     0,    1, 0,     0,  0, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 0,     'h11, 0, 0,     0,  0, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 8,     'h22, 0, 0,     0,  1, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 16,    'h33, 0, 0,     0,  2, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 24,    'h44, 0, 0,     0,  3, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 32,    'h55, 0, 0,     0,  4, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     0,  4, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  4, 1, 0,     'h11, 0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  3, 1, 8,     'h22, 0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  2, 1, 16,    'h33, 0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  1, 1, 24,    'h44, 0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  0, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 8,     'hAA, 0, 0,     0,  0, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 8,     'hBB, 1, 8,     0,  1, 0, 0,     0,    1, 'hAA, 0));
    vecs.push_back(mk(0, 0,     0,    1, 8,     0,  2, 0, 0,     0,    1, 'hBB, 0));
    vecs.push_back(mk(0, 0,     0,    1, 40,    0,  2, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    1, 8,     1,  2, 1, 8,     'hAA, 1, 'hBB, 0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  1, 1, 8,     'hBB, 0, 0,    0));
    vecs.push_back(mk(1, 16,    'h66, 0, 0,     0,  0, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    1, 20,    0,  1, 0, 0,     0,    0, 0,    1));
    vecs.push_back(mk(1, 20,    'h77, 1, 20,    0,  1, 0, 0,     0,    0, 0,    1));
    vecs.push_back(mk(0, 0,     0,    1, 20,    0,  2, 0, 0,     0,    0, 0,    1));
    vecs.push_back(mk(0, 0,     0,    1, 20,    1,  2, 1, 16,    'h66, 0, 0,    1));
    vecs.push_back(mk(0, 0,     0,    1, 20,    0,  1, 0, 0,     0,    1, 'h77, 0));
    vecs.push_back(mk(0, 0,     0,    1, 13,    0,  1, 0, 0,     0,    0, 0,    1));
    vecs.push_back(mk(0, 0,     0,    1, 12,    0,  1, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    1, 27,    0,  1, 0, 0,     0,    0, 0,    1));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  1, 1, 20,    'h77, 0, 0,    0));
    vecs.push_back(mk(1, 'h100, 'hA1, 0, 0,     0,  0, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 'h108, 'hA2, 0, 0,     0,  1, 0, 0,     0,    0, 0,    0));
    vecs.push_back(mk(1, 'h110, 'hA3, 0, 0,     1,  2, 1, 'h100, 'hA1, 0, 0,    0));
    vecs.push_back(mk(1, 'h118, 'hA4, 0, 0,     1,  2, 1, 'h108, 'hA2, 0, 0,    0));
    vecs.push_back(mk(1, 'h120, 'hA5, 0, 0,     1,  2, 1, 'h110, 'hA3, 0, 0,    0));
    vecs.push_back(mk(1, 'h128, 'hA6, 0, 0,     1,  2, 1, 'h118, 'hA4, 0, 0,    0));
    vecs.push_back(mk(1, 'h130, 'hA7, 0, 0,     1,  2, 1, 'h120, 'hA5, 0, 0,    0));
    vecs.push_back(mk(1, 'h138, 'hA8, 0, 0,     1,  2, 1, 'h128, 'hA6, 0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  2, 1, 'h130, 'hA7, 0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  1, 1, 'h138, 'hA8, 0, 0,    0));
    vecs.push_back(mk(0, 0,     0,    0, 0,     1,  0, 0, 0,     0,    0, 0,    0));

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      drive(v.sv, v.sa, v.sd, v.lv, v.la, v.de);
      #3;
      chk($sformatf("v%0d.count", i), 64'(count), 64'(v.cnt));
      chk($sformatf("v%0d.st_ready", i), 64'(st_ready), 64'(v.cnt != 3'd4));
      chk($sformatf("v%0d.empty", i), 64'(empty), 64'(v.cnt == 3'd0));
      chk($sformatf("v%0d.full", i), 64'(full), 64'(v.cnt == 3'd4));
      chk($sformatf("v%0d.mem_write", i), 64'(mem_write), 64'(v.mw));
      if (v.mw) begin
        chk($sformatf("v%0d.mem_addr", i), mem_addr, v.ma);
        chk($sformatf("v%0d.write_data", i), write_data, v.wd);
      end
      chk($sformatf("v%0d.ld_hit", i), 64'(ld_hit), 64'(v.hit));
      chk($sformatf("v%0d.ld_data", i), ld_data, v.ldd);
      chk($sformatf("v%0d.ld_conflict", i), 64'(ld_conflict), 64'(v.cf));
      next_cycle();
    end

    chk_mem(0, 'h11);
    chk_mem(8, 'hBB);
    chk_mem(16, 'h66);
    chk_mem(20, 'h77);
    chk_mem(24, 'h44);
    chk("mem[20].rejected_store", 64'(mem.exists(32)), 64'd0);
    for (int k = 0; k < 8; k++)
      chk_mem(64'h100 + 64'(8 * k), 64'hA1 + 64'(k));

    // Reset with pending entries plus concurrent store and drain.
    drive(1, 'h200, 'hB1, 0, 0, 0); next_cycle();
    drive(1, 'h208, 'hB2, 0, 0, 0); next_cycle();
    drive(1, 'h210, 'hB3, 0, 0, 0); next_cycle();
    drive(0, 0, 0, 0, 0, 0);
    #3;
    chk("rst.pre_count", 64'(count), 64'd3);
    next_cycle();
    reset = 1'b1;
    drive(1, 'h218, 'hB4, 0, 0, 1);
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      drive(0, 0, 0, 1, 'h208, 1);
      #3;
      chk($sformatf("rst%0d.count", c), 64'(count), 64'd0);
      chk($sformatf("rst%0d.empty", c), 64'(empty), 64'd1);
      chk($sformatf("rst%0d.mem_write", c), 64'(mem_write), 64'd0);
      chk($sformatf("rst%0d.ld_hit", c), 64'(ld_hit), 64'd0);
      chk($sformatf("rst%0d.ld_conflict", c), 64'(ld_conflict), 64'd0);
      next_cycle();
    end
    chk("rst.discarded_218", 64'(mem.exists(64'h218)), 64'd0);
    chk("rst.discarded_210", 64'(mem.exists(64'h210)), 64'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
